// File: rtl/ring_counter_4bit.sv
// Purpose : 4-bit self-correcting one-hot ring counter that rotates left on every clock.
// Latency : Q is the state register itself; it updates on the same rising edge that advances the state.
// Backpres: none. The counter free-runs with no enable, load or direction control.
//
// Ports
//   clk   : single clock; all state changes happen on its rising edge
//   reset : asynchronous, active-high; forces Q to INIT immediately and holds it there
//   Q     : ring counter state, driven directly from a 4-bit register
//
// Parameter
//   INIT  : one-hot value loaded on reset and when the register is found in a non-one-hot state
module ring_counter_4bit #(
    parameter logic [3:0] INIT = 4'b0001
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] Q
);

    logic [3:0] q_q;
    logic [3:0] q_d;
    logic       onehot;

    // One-hot test: nonzero, and clearing the lowest set bit leaves nothing.
    // This catches both 0000 and any multi-bit pattern, such as a power-up
    // value or an upset, so the ring self-recovers in a single edge.
    always_comb begin
        onehot = (q_q != 4'b0000) && ((q_q & (q_q - 4'd1)) == 4'b0000);
    end

    always_comb begin
        q_d = INIT;
        if (onehot) begin
            q_d = {q_q[2:0], q_q[3]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_ring_counter_4bit.sv
module tb_ring_counter_4bit;

    logic       clk;
    logic       reset;
    logic [3:0] Q;

    int n_tests;
    int n_fail;

    ring_counter_4bit #(.INIT(4'b0001)) dut (
        .clk  (clk),
        .reset(reset),
        .Q    (Q)
    );

    // 10 ns period, first rising edge at 5 ns
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, Q=%b", Q);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic [3:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: Q=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position of the single hot bit, advanced modulo 4.
    function automatic logic [3:0] model_q(input int pos);
        logic [3:0] one;
        one = 4'b0001;
        return one << pos;
    endfunction

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[14];
        int   pos;
        int   cnt [4];
        int   r;

        n_tests = 0;
        n_fail  = 0;

        // ---- reset hold across the 5 ns edge ----
        reset = 1'b1;
        #1  check("rst_t1", Q, 4'b0001);
        #3  check("rst_t4", Q, 4'b0001);
        #2  check("rst_t6_after_edge", Q, 4'b0001);
        #3  check("rst_t9", Q, 4'b0001);
        #1  reset = 1'b0;                          // t=10
        #1  check("release_no_change", Q, 4'b0001); // t=11

        // ---- free run from release through 110 ns ----
        pos = 0;
        for (int k = 0; k < 10; k++) begin
            edge_sample();
            pos = (pos + 1) % 4;
            check("run_seq", Q, model_q(pos));
        end
        // t=106, Q=0100

        // ---- asynchronous reset mid-sequence, between edges ----
        check("pre_async_0100", Q, 4'b0100);
        #2 reset = 1'b1;                            // t=108
        #1 check("async_rst_immediate", Q, 4'b0001);
        edge_sample();                              // 115 edge with reset high
        check("async_rst_hold_edge", Q, 4'b0001);
        @(negedge clk) reset = 1'b0;
        #1 check("async_release_no_change", Q, 4'b0001);
        edge_sample();
        check("after_async_1", Q, 4'b0010);
        edge_sample();
        check("after_async_2", Q, 4'b0100);

        // ---- release just after an edge: that edge must not have advanced Q ----
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check("late_release_hold", Q, 4'b0001);
        edge_sample();
        check("late_release_first", Q, 4'b0010);

        // ---- table-driven: reset sampled per edge ----
        vecs[0]  = '{1'b1, 4'b0001};
        vecs[1]  = '{1'b0, 4'b0010};
        vecs[2]  = '{1'b0, 4'b0100};
        vecs[3]  = '{1'b0, 4'b1000};
        vecs[4]  = '{1'b0, 4'b0001};  // wrap with no idle cycle
        vecs[5]  = '{1'b0, 4'b0010};
        vecs[6]  = '{1'b0, 4'b0100};
        vecs[7]  = '{1'b1, 4'b0001};
        vecs[8]  = '{1'b1, 4'b0001};
        vecs[9]  = '{1'b0, 4'b0010};
        vecs[10] = '{1'b0, 4'b0100};
        vecs[11] = '{1'b0, 4'b1000};
        vecs[12] = '{1'b1, 4'b0001};
        vecs[13] = '{1'b0, 4'b0010};
        foreach (vecs[i]) begin
            @(negedge clk) reset = vecs[i].rst;
            edge_sample();
            check($sformatf("vec%0d", i), Q, vecs[i].exp);
        end

        // ---- illegal states recover to INIT on the next edge ----
        @(negedge clk) reset = 1'b0;
        force dut.q_q = 4'b0000;
        #1 check("force_0000_applied", Q, 4'b0000);
        release dut.q_q;
        edge_sample();
        check("recover_from_0000", Q, 4'b0001);
        edge_sample();
        check("resume_after_0000", Q, 4'b0010);

        @(negedge clk);
        force dut.q_q = 4'b0110;
        #1 check("force_0110_applied", Q, 4'b0110);
        release dut.q_q;
        edge_sample();
        check("recover_from_0110", Q, 4'b0001);
        edge_sample();
        check("resume_after_0110", Q, 4'b0010);

        @(negedge clk);
        force dut.q_q = 4'b1111;
        #1 release dut.q_q;
        edge_sample();
        check("recover_from_1111", Q, 4'b0001);

        // ---- randomized reset activity against the model ----
        @(negedge clk) reset = 1'b1;
        edge_sample();
        pos = 0;
        check("rand_sync", Q, model_q(pos));
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                reset = 1'b1;
            end else if (r == 1) begin
                reset = 1'b0;
                #2 reset = 1'b1;
                #1 check("rand_async_pulse", Q, 4'b0001);
                pos = 0;
                #1 reset = 1'b0;
            end else begin
                reset = 1'b0;
            end
            @(posedge clk);
            if (reset) pos = 0;
            else       pos = (pos + 1) % 4;
            #1 check("rand_step", Q, model_q(pos));
        end

        // ---- 1000 continuous cycles: one-hot every sample, each bit 250 times ----
        @(negedge clk) reset = 1'b0;
        edge_sample();
        pos = (pos + 1) % 4;
        for (int b = 0; b < 4; b++) cnt[b] = 0;
        for (int k = 0; k < 1000; k++) begin
            edge_sample();
            pos = (pos + 1) % 4;
            check("long_run", Q, model_q(pos));
            n_tests++;
            if ($countones(Q) != 1) begin
                n_fail++;
                $display("FAIL long_onehot: Q=%b not one-hot at t=%0t", Q, $time);
            end
            for (int b = 0; b < 4; b++) if (Q[b]) cnt[b]++;
        end
        for (int b = 0; b < 4; b++) begin
            n_tests++;
            if (cnt[b] != 250) begin
                n_fail++;
                $display("FAIL long_bit_count: bit %0d high %0d times, expected 250", b, cnt[b]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_counter_4bit.md
RING_COUNTER_4BIT -- requirements
Module: ring_counter_4bit

Interface
REQ-001 Parameter: INIT, 4'b0001, one-hot value loaded on reset and on illegal-state recovery; SHALL contain exactly one 1 bit.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: Q  output  [3:0]  ring counter state, driven directly from a 4-bit register.
REQ-005 The block SHALL use one clock domain; reset is asynchronous and active-high.

Function
REQ-006 Q SHALL be a registered output with no combinational path from any input to Q.
REQ-007 On each clk rising edge with reset low and Q one-hot, Q SHALL rotate left by one: Q_next = {Q[2:0], Q[3]}.
REQ-008 The legal sequence from INIT=0001 SHALL be 0001 -> 0010 -> 0100 -> 1000 -> 0001, with period 4 clocks.
REQ-009 Wrap-around: when Q=1000, the next edge SHALL produce 0001, with no extra or idle cycle.
REQ-010 Latency: Q SHALL change on the same rising edge that advances the state, with 0 cycles of additional delay.
REQ-011 Illegal state: if Q is not one-hot (0000 or more than one bit set), the next rising edge SHALL load INIT.
REQ-012 Q SHALL never remain at 0000 for more than one clock edge while reset is low.
REQ-013 The counter SHALL have no enable, load or direction control; it advances on every clock edge after reset is released.

Reset
REQ-014 While reset is high, Q SHALL equal INIT (0001), independent of clk.
REQ-015 Asserting reset SHALL force Q to INIT immediately, without waiting for a clock edge, including mid-sequence.
REQ-016 Deasserting reset SHALL NOT change Q; the first rotation SHALL occur on the first rising edge that samples reset low.
REQ-017 If reset deasserts coincident with a rising edge, that edge SHALL NOT advance Q; rotation SHALL start on the following edge.
REQ-018 The Q value at power-up before the first reset SHALL be treated as undefined; REQ-011 recovers it.

Verification (clk period 10 ns, first rising edge at 5 ns)
REQ-019 Hold reset=1 for 0-10 ns -> Q=0001 throughout, including across the 5 ns edge.
REQ-020 Release reset at 10 ns and run 100 ns -> Q=0010 at 15 ns, 0100 at 25 ns, 1000 at 35 ns, 0001 at 45 ns, then the 4-cycle pattern repeats through 110 ns.
REQ-021 Assert reset asynchronously between edges while Q=0100 -> Q=0001 within the same time step, with no clock edge required; after release, Q follows 0010, 0100, ...
REQ-022 Force Q to 0000 (and separately to 0110), reset low -> the next edge gives Q=0001, then the normal sequence resumes.
REQ-023 Continuous run of 1000 cycles -> Q is one-hot at every sample, and each bit is high exactly once per 4 cycles.
